// File: rtl/check_flags_unit.sv
// Condition-flag register with force-enable, req/ack branch-condition check and a
// saturating taken-branch counter. Optional macro CHECK_BYPASS_EN forwards same-cycle flag updates.
module check_flags_unit #(
  parameter int                 WIDTH       = 2,
  parameter logic [WIDTH-1:0]   STICKY_MASK = WIDTH'(2'b01),
  parameter int                 CNT_W       = 8,
  parameter int                 SEL_W       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             flag_we,
  input  logic             clr,
  input  logic             enabling,
  output logic [WIDTH-1:0] checked,
  input  logic             chk_req,
  input  logic [1:0]       chk_mode,
  input  logic [SEL_W-1:0] chk_sel,
  output logic             chk_ready,
  output logic             chk_valid,
  output logic             chk_taken,
  input  logic             chk_ack,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_RESP = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] flag_q, flag_d;
  logic [0:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] eval_src;
  logic             accept;
  logic             result;

  // Mode 00/01 test one selected flag (out-of-range index reads as 0); 10 = any set, 11 = all clear.
  function automatic logic eval_cond(input logic [WIDTH-1:0] src,
                                     input logic [1:0]       mode,
                                     input logic [SEL_W-1:0] sel);
    logic sel_bit;
    if (int'(sel) < WIDTH) begin
      sel_bit = src[sel];
    end else begin
      sel_bit = 1'b0;
    end
    case (mode)
      2'b00:   eval_cond = (sel_bit == 1'b0);
      2'b01:   eval_cond = (sel_bit == 1'b1);
      2'b10:   eval_cond = |src;
      2'b11:   eval_cond = ~|src;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Flag next-state: clear beats accumulate, clr together with a write loads flag_in as-is.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (clr) begin
        flag_d[i] = flag_we ? flag_in[i] : 1'b0;
      end else if (flag_we) begin
        flag_d[i] = STICKY_MASK[i] ? (flag_q[i] | flag_in[i]) : flag_in[i];
      end else begin
        flag_d[i] = flag_q[i];
      end
    end
  end

  assign checked = flag_q | {WIDTH{enabling}};

  // Evaluation source: forwarded next-state when bypass is built in, registered flags otherwise.
  always_comb begin
`ifdef CHECK_BYPASS_EN
    eval_src = flag_d | {WIDTH{enabling}};
`else
    eval_src = checked;
`endif
  end

  assign accept = chk_req & (state_q == ST_IDLE);
  assign result = eval_cond(eval_src, chk_mode, chk_sel);

  // Handshake FSM: requests in RESP are dropped, ack in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (chk_req) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          taken_d = result;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          taken_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (chk_ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          taken_d = 1'b0;
        end else begin
          state_d = ST_RESP;
          valid_d = valid_q;
          taken_d = taken_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        taken_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Taken counter saturates rather than wrapping; clr wins over a same-cycle increment.
  always_comb begin
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept && result && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q  <= {WIDTH{1'b0}};
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      flag_q  <= flag_d;
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign chk_ready = ready_q;
  assign chk_valid = valid_q;
  assign chk_taken = taken_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_check_flags_unit.sv
// Directed table-driven bench for check_flags_unit (WIDTH=2, sticky bit 0, CNT_W=2).
module tb_check_flags_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] flag_in;
  logic       flag_we, clr, enabling, chk_req, chk_ack;
  logic [1:0] chk_mode;
  logic [0:0] chk_sel;
  logic [1:0] checked;
  logic       chk_ready, chk_valid, chk_taken;
  logic [1:0] taken_cnt;

  int n_vec = 0;
  int n_err = 0;

`ifdef CHECK_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  check_flags_unit #(.WIDTH(2), .STICKY_MASK(2'b01), .CNT_W(2), .SEL_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we(flag_we), .clr(clr),
    .enabling(enabling), .checked(checked), .chk_req(chk_req), .chk_mode(chk_mode),
    .chk_sel(chk_sel), .chk_ready(chk_ready), .chk_valid(chk_valid),
    .chk_taken(chk_taken), .chk_ack(chk_ack), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [1:0] fi;
    logic       we, cl, en, req;
    logic [1:0] mode;
    logic       sel, ack;
    logic [1:0] e_chk;
    logic       e_rdy, e_val, e_tkn;
    logic [1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic [1:0] fi, logic we, logic cl, logic en, logic req,
                              logic [1:0] mode, logic sel, logic ack, logic [1:0] e_chk,
                              logic e_rdy, logic e_val, logic e_tkn, logic [1:0] e_cnt);
    vec_t v;
    v.fi = fi; v.we = we; v.cl = cl; v.en = en; v.req = req; v.mode = mode; v.sel = sel;
    v.ack = ack; v.e_chk = e_chk; v.e_rdy = e_rdy; v.e_val = e_val; v.e_tkn = e_tkn;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_chk, input logic e_rdy,
                            input logic e_val, input logic e_tkn, input logic [1:0] e_cnt);
    n_vec++;
    check({tag, ".checked"},   32'(checked),   32'(e_chk));
    check({tag, ".chk_ready"}, 32'(chk_ready), 32'(e_rdy));
    check({tag, ".chk_valid"}, 32'(chk_valid), 32'(e_val));
    check({tag, ".chk_taken"}, 32'(chk_taken), 32'(e_tkn));
    check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(e_cnt));
  endtask

  // Drive at the falling edge, let one rising edge pass, compare 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    flag_in = v.fi; flag_we = v.we; clr = v.cl; enabling = v.en; chk_req = v.req;
    chk_mode = v.mode; chk_sel = v.sel; chk_ack = v.ack;
    @(posedge clk);
    #1;
    check_outs(tag, v.e_chk, v.e_rdy, v.e_val, v.e_tkn, v.e_cnt);
  endtask

  vec_t tbl[21];
  logic [1:0] exp_cnt;

  initial begin
    // fi    we    cl    en    req   mode   sel   ack   chk    rdy   val   tkn   cnt
    tbl[0]  = mk(2'b01,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,2'd0);
    tbl[1]  = mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,2'b01,1'b0,1'b1,1'b0,2'd0);
    tbl[2]  = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,2'd0);
    tbl[3]  = mk(2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,2'd0);
    tbl[4]  = mk(2'b00,1'b0,1'b0,1'b1,1'b1,2'b11,1'b0,1'b0,2'b11,1'b0,1'b1,1'b0,2'd0);
    tbl[5]  = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd0);
    tbl[6]  = mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd1);
    tbl[7]  = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd1);
    tbl[8]  = mk(2'b01,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,2'd1);
    tbl[9]  = mk(2'b10,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b11,1'b1,1'b0,1'b0,2'd1);
    tbl[10] = mk(2'b10,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0,1'b0,2'd0);
    tbl[11] = mk(2'b01,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,2'd0);
    tbl[12] = mk(2'b00,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,2'd0);
    tbl[13] = mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b01,1'b0,1'b1,1'b1,2'd1);
    tbl[14] = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,2'd1);
    tbl[15] = mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,1'b0,2'b01,1'b0,1'b1,1'b0,2'd1);
    tbl[16] = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,2'd1);
    tbl[17] = mk(2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,2'd0);
    tbl[18] = mk(2'b01,1'b1,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,2'b01,1'b0,1'b1,BYP,{1'b0,BYP});
    tbl[19] = mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,{1'b0,BYP});
    tbl[20] = mk(2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,2'd0);

    rst_n = 1'b0; flag_in = 2'b00; flag_we = 1'b0; clr = 1'b0; enabling = 1'b0;
    chk_req = 1'b0; chk_mode = 2'b00; chk_sel = 1'b0; chk_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Saturating counter: five taken checks (all-clear on zero flags).
    for (int k = 0; k < 5; k++) begin
      exp_cnt = (k < 2) ? 2'(k + 1) : 2'd3;
      apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,exp_cnt),
            $sformatf("sat%0d.req", k));
      apply(mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,exp_cnt),
            $sformatf("sat%0d.ack", k));
    end
    apply(mk(2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,2'd0), "sat.clr");

    // clr during RESP keeps the pending response; clr beats a same-cycle taken acceptance.
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd1), "clrresp.req");
    apply(mk(2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd0), "clrresp.clr");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd0), "clrresp.ack");
    apply(mk(2'b00,1'b0,1'b1,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd0), "clracc.req");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd0), "clracc.ack");

    // Back-to-back: req alongside ack is dropped, re-issue next cycle is accepted.
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd1), "b2b.req");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd1), "b2b.ackreq");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,2'd2), "b2b.reissue");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,2'd2), "b2b.ack");

    // Held response under extra requests, then async reset mid-RESP.
    apply(mk(2'b11,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,2'b11,1'b1,1'b0,1'b0,2'd0), "hold.load");
    apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b11,1'b0,1'b1,1'b1,2'd1), "hold.req");
    for (int k = 0; k < 4; k++) begin
      apply(mk(2'b00,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,2'b11,1'b0,1'b1,1'b1,2'd1),
            $sformatf("hold%0d", k));
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    chk_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_rst", 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
